// File: rtl/text_port_pkg.sv
`default_nettype none
// ============================================================================
// Module : text_port_pkg
// Brief  : Port map, status bit positions and state type for text_port_bridge.
// Rev    : 1.0  initial release
// ============================================================================
package text_port_pkg;

    localparam logic [7:0] PORT_ROW  = 8'h80;
    localparam logic [7:0] PORT_ATTR = 8'h81;
    localparam logic [7:0] PORT_COL  = 8'h82;
    localparam logic [7:0] PORT_CHAR = 8'h83;
    localparam logic [7:0] PORT_CTRL = 8'h84;
    localparam logic [7:0] PORT_STAT = 8'h85;

    localparam int STAT_BUSY = 0;
    localparam int STAT_OVR  = 1;

    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/text_port_bridge_if.sv
`default_nettype none
// ============================================================================
// Module : text_port_bridge_if
// Brief  : CPU port bus plus display-memory write side of the text bridge.
// Rev    : 1.0  initial release
// ============================================================================
interface text_port_bridge_if #(
    parameter int ROW_BITS = 5,
    parameter int COL_BITS = 7
);
    logic [7:0]                   port_id;
    logic                         write_strobe;
    logic                         read_strobe;
    logic [7:0]                   out_port;
    logic [7:0]                   in_port;
    logic                         disp_en;
    logic [ROW_BITS+COL_BITS-1:0] disp_addr;
    logic [15:0]                  disp_data;
    logic                         busy;

    modport slave (
        input  port_id, write_strobe, read_strobe, out_port,
        output in_port, disp_en, disp_addr, disp_data, busy
    );

    modport master (
        output port_id, write_strobe, read_strobe, out_port,
        input  in_port, disp_en, disp_addr, disp_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/text_cursor.sv
`default_nettype none
// ============================================================================
// Module : text_cursor
// Brief  : Row/column position register with clamped load and row-major wrap.
// Rev    : 1.0  initial release
// ============================================================================
module text_cursor #(
    parameter int COLS     = 80,
    parameter int ROWS     = 30,
    parameter int COL_BITS = 7,
    parameter int ROW_BITS = 5
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                i_clr,
    input  wire logic                i_ld_row,
    input  wire logic                i_ld_col,
    input  wire logic [7:0]          i_ld_val,
    input  wire logic                i_inc,
    output logic      [ROW_BITS-1:0] o_row,
    output logic      [COL_BITS-1:0] o_col
);
    localparam logic [ROW_BITS-1:0] C_ROW_MAX = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0] C_COL_MAX = COL_BITS'(COLS - 1);

    logic [ROW_BITS-1:0] r_row;
    logic [COL_BITS-1:0] r_col;
    logic [ROW_BITS-1:0] w_row_nxt;
    logic [COL_BITS-1:0] w_col_nxt;
    logic [ROW_BITS-1:0] w_row_clamp;
    logic [COL_BITS-1:0] w_col_clamp;

    always_comb begin
        w_row_clamp = (32'(i_ld_val) >= 32'(ROWS)) ? C_ROW_MAX : ROW_BITS'(i_ld_val);
        w_col_clamp = (32'(i_ld_val) >= 32'(COLS)) ? C_COL_MAX : COL_BITS'(i_ld_val);
    end

    // Clear has priority; increment and loads are never requested together.
    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        if (i_clr) begin
            w_row_nxt = '0;
            w_col_nxt = '0;
        end else if (i_inc) begin
            if (r_col >= C_COL_MAX) begin
                w_col_nxt = '0;
                w_row_nxt = (r_row >= C_ROW_MAX) ? '0 : r_row + ROW_BITS'(1);
            end else begin
                w_col_nxt = r_col + COL_BITS'(1);
            end
        end else begin
            if (i_ld_row) w_row_nxt = w_row_clamp;
            if (i_ld_col) w_col_nxt = w_col_clamp;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row <= '0;
            r_col <= '0;
        end else begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
        end
    end

    assign o_row = r_row;
    assign o_col = r_col;

endmodule
`default_nettype wire

// File: rtl/text_port_bridge.sv
`default_nettype none
// ============================================================================
// Module : text_port_bridge
// Brief  : kcpsm3 port I/O to character display memory, with cursor and clear.
// Rev    : 1.0  initial release
// ============================================================================
module text_port_bridge
    import text_port_pkg::*;
#(
    parameter int          COLS     = 80,
    parameter int          ROWS     = 30,
    parameter int          COL_BITS = 7,
    parameter int          ROW_BITS = 5,
    parameter logic [7:0]  ATTR_RST = 8'h0F
) (
    input  wire logic      clk,
    input  wire logic      reset,
    text_port_bridge_if.slave bus
);
    localparam int                  ADDR_W    = ROW_BITS + COL_BITS;
    localparam logic [ROW_BITS-1:0] C_ROW_MAX = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0] C_COL_MAX = COL_BITS'(COLS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_attr;
    logic                r_ovr;
    logic [7:0]          r_in_port;
    logic                r_disp_en;
    logic [ADDR_W-1:0]   r_disp_addr;
    logic [15:0]         r_disp_data;

    logic [ROW_BITS-1:0] w_cur_row;
    logic [COL_BITS-1:0] w_cur_col;
    logic [ROW_BITS-1:0] w_scan_row;
    logic [COL_BITS-1:0] w_scan_col;

    logic                w_busy;
    logic [COL_BITS-1:0] w_dcol;
    logic                w_is_direct;
    logic                w_direct_ok;
    logic                w_is_cchar;
    logic                w_char_drop;
    logic                w_ld_row;
    logic                w_ld_col;
    logic                w_ld_attr;
    logic                w_start;
    logic                w_scan_last;
    logic                w_cur_inc;
    logic                w_stat_rd;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [15:0]         w_wr_data;
    logic [7:0]          w_rd_data;

    assign w_busy      = (r_state == ST_CLEAR);
    assign w_dcol      = bus.port_id[COL_BITS-1:0];
    assign w_is_direct = bus.write_strobe && !bus.port_id[7];
    assign w_direct_ok = (32'(w_dcol) < 32'(COLS));
    assign w_is_cchar  = bus.write_strobe && (bus.port_id == PORT_CHAR);
    assign w_char_drop = w_busy && (w_is_direct || w_is_cchar);
    assign w_ld_row    = bus.write_strobe && (bus.port_id == PORT_ROW);
    assign w_ld_col    = bus.write_strobe && (bus.port_id == PORT_COL);
    assign w_ld_attr   = bus.write_strobe && (bus.port_id == PORT_ATTR);
    assign w_start     = bus.write_strobe && (bus.port_id == PORT_CTRL) && bus.out_port[0] && !w_busy;
    assign w_scan_last = w_busy && (w_scan_row == C_ROW_MAX) && (w_scan_col == C_COL_MAX);
    assign w_cur_inc   = w_is_cchar && !w_busy;
    assign w_stat_rd   = bus.read_strobe && (bus.port_id == PORT_STAT);

    // The cursor is homed on the clear's last write, overriding any row/col load in that cycle.
    text_cursor #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .COL_BITS (COL_BITS),
        .ROW_BITS (ROW_BITS)
    ) u_cursor (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_scan_last),
        .i_ld_row (w_ld_row),
        .i_ld_col (w_ld_col),
        .i_ld_val (bus.out_port),
        .i_inc    (w_cur_inc),
        .o_row    (w_cur_row),
        .o_col    (w_cur_col)
    );

    text_cursor #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .COL_BITS (COL_BITS),
        .ROW_BITS (ROW_BITS)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_start),
        .i_ld_row (1'b0),
        .i_ld_col (1'b0),
        .i_ld_val (8'h00),
        .i_inc    (w_busy),
        .o_row    (w_scan_row),
        .o_col    (w_scan_col)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start)     w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (w_scan_last) w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Address/data hold their last value between writes.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_disp_addr;
        w_wr_data = r_disp_data;
        if (w_busy) begin
            w_wr_en   = 1'b1;
            w_wr_addr = {w_scan_row, w_scan_col};
            w_wr_data = {r_attr, CHAR_SPACE};
        end else if (w_is_direct && w_direct_ok) begin
            w_wr_en   = 1'b1;
            w_wr_addr = {w_cur_row, w_dcol};
            w_wr_data = {r_attr, bus.out_port};
        end else if (w_is_cchar) begin
            w_wr_en   = 1'b1;
            w_wr_addr = {w_cur_row, w_cur_col};
            w_wr_data = {r_attr, bus.out_port};
        end
    end

    always_comb begin
        w_rd_data = 8'h00;
        case (bus.port_id)
            PORT_ROW:  w_rd_data = 8'(w_cur_row);
            PORT_ATTR: w_rd_data = r_attr;
            PORT_COL:  w_rd_data = 8'(w_cur_col);
            PORT_STAT: begin
                w_rd_data            = 8'h00;
                w_rd_data[STAT_BUSY] = w_busy;
                w_rd_data[STAT_OVR]  = r_ovr;
            end
            default:   w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_attr      <= ATTR_RST;
            r_ovr       <= 1'b0;
            r_in_port   <= 8'h00;
            r_disp_en   <= 1'b0;
            r_disp_addr <= '0;
            r_disp_data <= '0;
        end else begin
            if (w_ld_attr) r_attr <= bus.out_port;
            if (w_char_drop)    r_ovr <= 1'b1;
            else if (w_stat_rd) r_ovr <= 1'b0;
            r_in_port   <= w_rd_data;
            r_disp_en   <= w_wr_en;
            r_disp_addr <= w_wr_addr;
            r_disp_data <= w_wr_data;
        end
    end

    assign bus.in_port   = r_in_port;
    assign bus.disp_en   = r_disp_en;
    assign bus.disp_addr = r_disp_addr;
    assign bus.disp_data = r_disp_data;
    assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_text_port_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_text_port_bridge
// Brief  : Directed and random stimulus against a linear-position reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_text_port_bridge;
    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int CB   = 7;
    localparam int RB   = 5;
    localparam int NPOS = ROWS * COLS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_clears = 0;

    text_port_bridge_if #(.ROW_BITS(RB), .COL_BITS(CB)) bus ();

    text_port_bridge #(
        .COLS(COLS), .ROWS(ROWS), .COL_BITS(CB), .ROW_BITS(RB), .ATTR_RST(8'h0F)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          row;
        int          col;
        logic [7:0]  attr;
        logic        ovr;
        logic        busy;
        int          idx;
        logic        en;
        logic [11:0] addr;
        logic [15:0] data;
        logic [7:0]  in_port;
    } model_t;

    model_t m;

    function automatic model_t m_reset();
        model_t r;
        r.row = 0; r.col = 0; r.attr = 8'h0F; r.ovr = 1'b0; r.busy = 1'b0;
        r.idx = 0; r.en = 1'b0; r.addr = '0; r.data = '0; r.in_port = 8'h00;
        return r;
    endfunction

    function automatic logic [11:0] pos_addr(input int r, input int c);
        return 12'(r * (2 ** CB) + c);
    endfunction

    // One clock of the display bridge, computed from linear screen positions.
    function automatic model_t step(input model_t s, input logic [7:0] pid, input logic ws,
                                    input logic rs, input logic [7:0] op);
        model_t n;
        logic   set_ovr;
        int     p;
        n = s;
        n.en = 1'b0;
        set_ovr = 1'b0;
        case (pid)
            8'h80:   n.in_port = 8'(s.row);
            8'h81:   n.in_port = s.attr;
            8'h82:   n.in_port = 8'(s.col);
            8'h85:   n.in_port = {6'b0, s.ovr, s.busy};
            default: n.in_port = 8'h00;
        endcase
        if (ws) begin
            if (pid < 8'h80) begin
                if (s.busy) set_ovr = 1'b1;
                else if (int'(pid) < COLS) begin
                    n.en = 1'b1; n.addr = pos_addr(s.row, int'(pid)); n.data = {s.attr, op};
                end
            end else if (pid == 8'h80) n.row  = (int'(op) >= ROWS) ? ROWS - 1 : int'(op);
            else if (pid == 8'h81)     n.attr = op;
            else if (pid == 8'h82)     n.col  = (int'(op) >= COLS) ? COLS - 1 : int'(op);
            else if (pid == 8'h83) begin
                if (s.busy) set_ovr = 1'b1;
                else begin
                    n.en = 1'b1; n.addr = pos_addr(s.row, s.col); n.data = {s.attr, op};
                    p = (s.row * COLS + s.col + 1) % NPOS;
                    n.row = p / COLS; n.col = p % COLS;
                end
            end else if (pid == 8'h84 && op[0] && !s.busy) begin
                n.busy = 1'b1; n.idx = 0;
            end
        end
        if (s.busy) begin
            n.en = 1'b1;
            n.addr = pos_addr(s.idx / COLS, s.idx % COLS);
            n.data = {s.attr, 8'h20};
            n.idx = s.idx + 1;
            if (s.idx == NPOS - 1) begin
                n.busy = 1'b0; n.row = 0; n.col = 0;
            end
        end
        if (set_ovr) n.ovr = 1'b1;
        else if (rs && pid == 8'h85) n.ovr = 1'b0;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= m_reset();
        else        m <= step(m, bus.port_id, bus.write_strobe, bus.read_strobe, bus.out_port);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy",      32'(bus.busy),      32'(m.busy));
            check("disp_en",   32'(bus.disp_en),   32'(m.en));
            check("disp_addr", 32'(bus.disp_addr), 32'(m.addr));
            check("disp_data", 32'(bus.disp_data), 32'(m.data));
            check("in_port",   32'(bus.in_port),   32'(m.in_port));
        end
    end

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        @(posedge clk); #1;
        bus.port_id = p; bus.out_port = d; bus.write_strobe = 1'b1;
        @(posedge clk); #1;
        bus.write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] p, output logic [7:0] v);
        @(posedge clk); #1;
        bus.port_id = p; bus.read_strobe = 1'b1;
        @(posedge clk); #1;
        bus.read_strobe = 1'b0;
        v = bus.in_port;
    endtask

    task automatic idle(input logic [7:0] p);
        @(posedge clk); #1;
        bus.port_id = p;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (bus.busy && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] p;
        logic [7:0] d;
        int         busy_cnt, en_cnt, bad_data, dup, covered;
        bit         seen [0:4095];

        bus.port_id = 8'h00; bus.out_port = 8'h00;
        bus.write_strobe = 1'b0; bus.read_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_disp_en",   32'(bus.disp_en),   32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_disp_addr", 32'(bus.disp_addr), 32'd0);
        check("rst_in_port",   32'(bus.in_port),   32'd0);
        rst_n = 1'b1;

        // Direct character write
        wr(8'h80, 8'd3);
        wr(8'h81, 8'h1E);
        wr(8'h05, 8'h41);
        check("t1_en",   32'(bus.disp_en),   32'd1);
        check("t1_addr", 32'(bus.disp_addr), 32'h185);
        check("t1_data", 32'(bus.disp_data), 32'h1E41);
        @(posedge clk); #1;
        check("t1_pulse", 32'(bus.disp_en), 32'd0);

        // Auto-increment with wrap from the bottom-right corner
        wr(8'h82, 8'd79);
        wr(8'h80, 8'd29);
        wr(8'h83, 8'h41);
        check("t2_addrA", 32'(bus.disp_addr), 32'hECF);
        check("t2_dataA", 32'(bus.disp_data), 32'h1E41);
        wr(8'h83, 8'h42);
        check("t2_addrB", 32'(bus.disp_addr), 32'h000);
        wr(8'h83, 8'h43);
        check("t2_addrC", 32'(bus.disp_addr), 32'h001);
        check("t2_dataC", 32'(bus.disp_data), 32'h1E43);
        rd(8'h82, v);
        check("t2_col", 32'(v), 32'd2);

        // Full clear
        wr(8'h81, 8'h0F);
        wr(8'h84, 8'h01);
        busy_cnt = 0; en_cnt = 0; bad_data = 0; dup = 0; covered = 0;
        for (int i = 0; i < 4096; i++) seen[i] = 1'b0;
        for (int k = 0; k < 2405; k++) begin
            if (bus.busy) busy_cnt++;
            if (bus.disp_en) begin
                en_cnt++;
                if (bus.disp_data != 16'h0F20) bad_data++;
                if (seen[bus.disp_addr]) dup++;
                seen[bus.disp_addr] = 1'b1;
            end
            @(posedge clk); #1;
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (seen[r * 128 + c]) covered++;
        check("t3_busy_cycles", 32'(busy_cnt), 32'd2400);
        check("t3_writes",      32'(en_cnt),   32'd2400);
        check("t3_covered",     32'(covered),  32'd2400);
        check("t3_dup",         32'(dup),      32'd0);
        check("t3_bad_data",    32'(bad_data), 32'd0);
        rd(8'h80, v);
        check("t3_row", 32'(v), 32'd0);
        rd(8'h82, v);
        check("t3_col", 32'(v), 32'd0);

        // Char write while clearing is dropped and flagged
        wr(8'h84, 8'h01);
        wr(8'h82, 8'd7);
        wr(8'h83, 8'h58);
        check("t4_en",   32'(bus.disp_en),   32'd1);
        check("t4_data", 32'(bus.disp_data), 32'h0F20);
        rd(8'h82, v);
        check("t4_col", 32'(v), 32'd7);
        rd(8'h85, v);
        check("t4_stat1", 32'(v), 32'h03);
        rd(8'h85, v);
        check("t4_stat2", 32'(v), 32'h01);
        wait_idle("t4_timeout");
        rd(8'h85, v);
        check("t4_stat3", 32'(v), 32'h00);
        rd(8'h82, v);
        check("t4_col_home", 32'(v), 32'd0);

        // Out-of-range column and row clamp
        wr(8'h55, 8'h21);
        check("t5_no_en", 32'(bus.disp_en), 32'd0);
        wr(8'h80, 8'd40);
        rd(8'h80, v);
        check("t5_row_clamp", 32'(v), 32'd29);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            d = 8'($urandom);
            if (sel < 30) begin
                wr(8'($urandom_range(0, 127)), d);
            end else if (sel < 55) begin
                p = 8'($urandom_range(8'h80, 8'h86));
                if (p == 8'h84) begin
                    if (n_clears < 4 && $urandom_range(0, 3) == 0 && !bus.busy) n_clears++;
                    else d[0] = 1'b0;
                end
                wr(p, d);
            end else if (sel < 75) begin
                rd(8'($urandom_range(8'h7E, 8'h87)), v);
            end else begin
                idle(8'($urandom));
            end
        end
        wait_idle("rand_timeout");

        // Reset in the middle of a clear
        wr(8'h81, 8'h33);
        wr(8'h84, 8'h01);
        repeat (500) @(posedge clk);
        #2;
        check("t6_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_busy",    32'(bus.busy),    32'd0);
        check("t6_disp_en", 32'(bus.disp_en), 32'd0);
        check("t6_in_port", 32'(bus.in_port), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd(8'h85, v);
        check("t6_stat", 32'(v), 32'h00);
        rd(8'h81, v);
        check("t6_attr", 32'(v), 32'h0F);
        rd(8'h80, v);
        check("t6_row", 32'(v), 32'd0);
        rd(8'h82, v);
        check("t6_col", 32'(v), 32'd0);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
